// File: rtl/swapout_sequence_player_if.sv
`default_nettype none
// ============================================================================
// Module   : swapout_sequence_player_if
// Brief    : Table-write, sequence control and TX event handshake bundle
//            between the swapout start logic / EVG TX arbiter and the
//            sequence player.
// Revision : 1.0 - initial release
// ============================================================================
interface swapout_sequence_player_if #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DELAY_WIDTH = 16
);
  logic                       tblWrEnable;
  logic [ADDR_WIDTH-1:0]      tblWrAddr;
  logic [DELAY_WIDTH+7:0]     tblWrData;
  logic                       sequenceStart;
  logic                       sequenceAbort;
  logic [7:0]                 evCode;
  logic                       evValid;
  logic                       evReady;
  logic                       busy;
  logic                       startIgnored;
  logic [15:0]                sequenceCount;

  // Environment side: writes the table, starts/aborts, accepts events
  modport master (
    output tblWrEnable, tblWrAddr, tblWrData, sequenceStart, sequenceAbort, evReady,
    input  evCode, evValid, busy, startIgnored, sequenceCount
  );

  // Player side
  modport slave (
    input  tblWrEnable, tblWrAddr, tblWrData, sequenceStart, sequenceAbort, evReady,
    output evCode, evValid, busy, startIgnored, sequenceCount
  );
endinterface
`default_nettype wire

// File: rtl/swapout_sequence_player.sv
`default_nettype none
// ============================================================================
// Module   : swapout_sequence_player
// Brief    : On a start pulse, walks a writable (delay, event code) table and
//            offers each code to the TX event arbiter via valid/ready.
//            Code 0x00 terminates a sequence early; otherwise the walk stops
//            after the last table entry.
// Revision : 1.0 - initial release
// ============================================================================
module swapout_sequence_player #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                     evgTxClk,
  input  logic                     evgTxRst_n,
  swapout_sequence_player_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} state_t;

  state_t                  state, state_next;
  logic [1:0]              rst_sync;
  logic                    rst_int_n;
  logic [DELAY_WIDTH+7:0]  mem [DEPTH];
  logic [DELAY_WIDTH+7:0]  rd_data;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
  logic [DELAY_WIDTH-1:0]  delay_cnt, cnt_next;
  logic                    fetch_phase, phase_next;
  logic [7:0]              entry_code, entry_code_next;
  logic [7:0]              ev_code, ev_code_next;
  logic                    ev_valid, ev_valid_next;
  logic                    busy_r;
  logic                    start_ignored, ignored_next;
  logic [15:0]             seq_count, count_next;

  // Reset synchroniser: assertion is immediate, release is aligned to the clock
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Event table: one write port, one registered read port addressed by the
  // entry pointer; a same-address write on the read edge returns old data
  always_ff @(posedge evgTxClk) begin
    if (bus.tblWrEnable) mem[bus.tblWrAddr] <= bus.tblWrData;
    rd_data <= mem[ptr];
  end

  // State and datapath registers
  always_ff @(posedge evgTxClk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= IDLE;
      ptr           <= '0;
      delay_cnt     <= '0;
      fetch_phase   <= 1'b0;
      entry_code    <= 8'h00;
      ev_code       <= 8'h00;
      ev_valid      <= 1'b0;
      busy_r        <= 1'b0;
      start_ignored <= 1'b0;
      seq_count     <= 16'h0000;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      delay_cnt     <= cnt_next;
      fetch_phase   <= phase_next;
      entry_code    <= entry_code_next;
      ev_code       <= ev_code_next;
      ev_valid      <= ev_valid_next;
      busy_r        <= (state_next != IDLE);
      start_ignored <= ignored_next;
      seq_count     <= count_next;
    end
  end

  // Next-state and output logic; abort overrides every non-idle transition
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    cnt_next        = delay_cnt;
    phase_next      = fetch_phase;
    entry_code_next = entry_code;
    ev_code_next    = ev_code;
    ev_valid_next   = ev_valid;
    count_next      = seq_count;
    ignored_next    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.sequenceStart && !bus.sequenceAbort) begin
          state_next = FETCH;
          ptr_next   = '0;
          phase_next = 1'b0;
        end
      end
      FETCH: begin
        // First cycle issues the read, second cycle consumes the RAM output
        if (!fetch_phase) begin
          phase_next = 1'b1;
        end else if (rd_data[7:0] == 8'h00) begin
          state_next = IDLE;
          count_next = seq_count + 16'd1;
        end else begin
          cnt_next        = rd_data[DELAY_WIDTH+7:8];
          entry_code_next = rd_data[7:0];
          state_next      = WAIT;
        end
      end
      WAIT: begin
        if (delay_cnt == '0) begin
          ev_code_next  = entry_code;
          ev_valid_next = 1'b1;
          state_next    = EMIT;
        end else begin
          cnt_next = delay_cnt - DELAY_WIDTH'(1);
        end
      end
      EMIT: begin
        if (bus.evReady) begin
          ev_valid_next = 1'b0;
          if (ptr == LAST_ADDR) begin
            state_next = IDLE;
            count_next = seq_count + 16'd1;
          end else begin
            ptr_next   = ptr + ADDR_WIDTH'(1);
            phase_next = 1'b0;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state != IDLE) begin
      if (bus.sequenceAbort) begin
        state_next    = IDLE;
        ev_valid_next = 1'b0;
        count_next    = seq_count;
      end else if (bus.sequenceStart) begin
        ignored_next = 1'b1;
      end
    end
  end

  assign bus.evCode        = ev_code;
  assign bus.evValid       = ev_valid;
  assign bus.busy          = busy_r;
  assign bus.startIgnored  = start_ignored;
  assign bus.sequenceCount = seq_count;

endmodule
`default_nettype wire

// File: tb/tb_swapout_sequence_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_swapout_sequence_player
// Brief    : Self-checking bench for swapout_sequence_player with a
//            table-level reference model of the emitted event stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swapout_sequence_player;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [7:0]    tbl_code  [DEPTH];
  int            tbl_delay [DEPTH];
  logic [15:0]   exp_count;

  swapout_sequence_player_if #(.ADDR_WIDTH(AW), .DELAY_WIDTH(DW)) bus ();

  swapout_sequence_player #(.ADDR_WIDTH(AW), .DELAY_WIDTH(DW)) dut (
    .evgTxClk   (clk),
    .evgTxRst_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int delay, input logic [7:0] code);
    bus.tblWrEnable = 1'b1;
    bus.tblWrAddr   = AW'(addr);
    bus.tblWrData   = {DW'(delay), code};
    tick();
    bus.tblWrEnable = 1'b0;
    tbl_code[addr]  = code;
    tbl_delay[addr] = delay;
  endtask

  task automatic load_basic_table();
    write_entry(0, 5, 8'h70);
    write_entry(1, 0, 8'h71);
    write_entry(2, 2, 8'h00);
  endtask

  // Plays one full sequence from the model table and checks every event's
  // code, rise latency, stability under stall, and the sequence ending.
  task automatic run_sequence(input int max_stall, input bit probe_ignore);
    logic [7:0] q_code[$];
    int         q_delay[$];
    bit         term_null;
    term_null = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_code[i] == 8'h00) begin
        term_null = 1'b1;
        break;
      end
      q_code.push_back(tbl_code[i]);
      q_delay.push_back(tbl_delay[i]);
    end

    bus.sequenceStart = 1'b1;
    tick();
    bus.sequenceStart = 1'b0;

    for (int e = 0; e < q_code.size(); e++) begin
      int k;
      bit got;
      int stall;
      k = 0;
      got = 1'b0;
      while (k < q_delay[e] + 20) begin
        tick();
        k++;
        if (probe_ignore && e == 0) begin
          if (k == 4) bus.sequenceStart = 1'b1;
          if (k == 5) begin
            bus.sequenceStart = 1'b0;
            tests++;
            if (bus.startIgnored !== 1'b1) begin
              fails++;
              $display("FAIL start_ignored_pulse: got %b expected 1", bus.startIgnored);
            end
          end
          if (k == 6) begin
            tests++;
            if (bus.startIgnored !== 1'b0) begin
              fails++;
              $display("FAIL start_ignored_width: got %b expected 0", bus.startIgnored);
            end
          end
        end
        if (bus.evValid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      tests++;
      if (!got || k != q_delay[e] + 3) begin
        fails++;
        $display("FAIL event_latency[%0d]: got %0d cycles expected %0d", e, got ? k : -1, q_delay[e] + 3);
      end
      tests++;
      if (bus.evCode !== q_code[e]) begin
        fails++;
        $display("FAIL event_code[%0d]: got %h expected %h", e, bus.evCode, q_code[e]);
      end
      stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      if (stall > 0) begin
        bus.evReady = 1'b0;
        repeat (stall) begin
          tick();
          tests++;
          if (bus.evValid !== 1'b1 || bus.evCode !== q_code[e]) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got valid=%b code=%h expected valid=1 code=%h",
                     e, bus.evValid, bus.evCode, q_code[e]);
          end
        end
        bus.evReady = 1'b1;
      end
      tick();
      tests++;
      if (bus.evValid !== 1'b0) begin
        fails++;
        $display("FAIL valid_after_handshake[%0d]: got %b expected 0", e, bus.evValid);
      end
    end

    if (term_null) begin
      tick();
      tests++;
      if (bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_during_end_fetch: got %b expected 1", bus.busy);
      end
      tick();
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_at_end: got %b expected 0", bus.busy);
    end
    exp_count = exp_count + 16'd1;
    tests++;
    if (bus.sequenceCount !== exp_count) begin
      fails++;
      $display("FAIL sequence_count: got %0d expected %0d", bus.sequenceCount, exp_count);
    end
    repeat (6) begin
      tick();
      tests++;
      if (bus.evValid !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_end: got valid=%b busy=%b expected 0/0", bus.evValid, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if (bus.evValid !== 1'b0 || bus.evCode !== 8'h00) begin
      fails++;
      $display("FAIL reset_event: got valid=%b code=%h expected 0/00", bus.evValid, bus.evCode);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    tests++;
    if (bus.startIgnored !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: got %b expected 0", bus.startIgnored);
    end
    tests++;
    if (bus.sequenceCount !== 16'h0000) begin
      fails++;
      $display("FAIL reset_count: got %0d expected 0", bus.sequenceCount);
    end
  endtask

  task automatic test_basic();
    load_basic_table();
    run_sequence(0, 1'b0);
  endtask

  task automatic test_stall();
    int k;
    bit got;
    bus.sequenceStart = 1'b1;
    tick();
    bus.sequenceStart = 1'b0;
    k = 0;
    got = 1'b0;
    while (k < 30) begin
      tick();
      k++;
      if (bus.evValid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got || k != 8) begin
      fails++;
      $display("FAIL stall_first_latency: got %0d expected 8", got ? k : -1);
    end
    bus.evReady = 1'b0;
    repeat (10) begin
      tick();
      tests++;
      if (bus.evValid !== 1'b1 || bus.evCode !== 8'h70) begin
        fails++;
        $display("FAIL stall_10_hold: got valid=%b code=%h expected 1/70", bus.evValid, bus.evCode);
      end
    end
    bus.evReady = 1'b1;
    tick();
    k = 0;
    got = 1'b0;
    while (k < 30) begin
      tick();
      k++;
      if (bus.evValid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got || k != 3 || bus.evCode !== 8'h71) begin
      fails++;
      $display("FAIL stall_second_event: got %0d cycles code=%h expected 3 cycles code=71",
               got ? k : -1, bus.evCode);
    end
    tick();
    tick();
    tick();
    exp_count = exp_count + 16'd1;
    tests++;
    if (bus.busy !== 1'b0 || bus.sequenceCount !== exp_count) begin
      fails++;
      $display("FAIL stall_end: got busy=%b count=%0d expected 0/%0d", bus.busy, bus.sequenceCount, exp_count);
    end
  endtask

  task automatic test_start_ignored();
    run_sequence(0, 1'b1);
  endtask

  task automatic test_abort();
    int k;
    bus.sequenceStart = 1'b1;
    tick();
    bus.sequenceStart = 1'b0;
    k = 0;
    while (k < 30 && bus.evValid !== 1'b1) begin
      tick();
      k++;
    end
    bus.evReady = 1'b0;
    tick();
    tick();
    bus.sequenceAbort = 1'b1;
    tick();
    bus.sequenceAbort = 1'b0;
    tests++;
    if (bus.evValid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_in_emit: got valid=%b busy=%b expected 0/0", bus.evValid, bus.busy);
    end
    tests++;
    if (bus.sequenceCount !== exp_count) begin
      fails++;
      $display("FAIL abort_count: got %0d expected %0d", bus.sequenceCount, exp_count);
    end
    bus.evReady = 1'b1;
    tick();
    bus.sequenceStart = 1'b1;
    bus.sequenceAbort = 1'b1;
    tick();
    bus.sequenceStart = 1'b0;
    bus.sequenceAbort = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.startIgnored !== 1'b0) begin
      fails++;
      $display("FAIL abort_and_start_idle: got busy=%b ignored=%b expected 0/0", bus.busy, bus.startIgnored);
    end
    repeat (3) tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_start_no_run: got busy=%b expected 0", bus.busy);
    end
    run_sequence(0, 1'b0);
  endtask

  task automatic test_full_table();
    for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 8'($urandom_range(1, 255)));
    run_sequence(2, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [7:0] c;
        c = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        write_entry(i, int'($urandom_range(0, 6)), c);
      end
      run_sequence(3, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    load_basic_table();
    for (int i = 3; i < DEPTH; i++) write_entry(i, 1, 8'h00);
    bus.sequenceStart = 1'b1;
    tick();
    bus.sequenceStart = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.busy !== 1'b1 || bus.sequenceCount === 16'h0000) begin
      fails++;
      $display("FAIL pre_reset_state: got busy=%b count=%0d expected busy=1 count!=0", bus.busy, bus.sequenceCount);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.evValid !== 1'b0 || bus.busy !== 1'b0 || bus.sequenceCount !== 16'h0000) begin
      fails++;
      $display("FAIL async_reset: got valid=%b busy=%b count=%0d expected 0/0/0",
               bus.evValid, bus.busy, bus.sequenceCount);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    exp_count = 16'h0000;
    run_sequence(0, 1'b0);
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    exp_count         = 16'h0000;
    rst_n             = 1'b0;
    bus.tblWrEnable   = 1'b0;
    bus.tblWrAddr     = '0;
    bus.tblWrData     = '0;
    bus.sequenceStart = 1'b0;
    bus.sequenceAbort = 1'b0;
    bus.evReady       = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_code[i]  = 8'h00;
      tbl_delay[i] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_abort();
    test_full_table();
    test_random();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
